// File: rtl/simd_reduce_drain.sv
// Reduces 64 signed lane products into 1/2/4/8 group sums, accumulates them per packet,
// then rounds, shifts and saturates each group for a valid/ready output port.
module simd_reduce_drain #(
    parameter int MAC_BW  = 8,
    parameter int ACC_EXT = 8,
    parameter int OUT_BW  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              mode,
    input  logic [4:0]              shift,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic [64*2*MAC_BW-1:0]  iC,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [8*OUT_BW-1:0]     oD,
    output logic [7:0]              out_sat
);
    localparam int NG     = 8;
    localparam int LW     = 2 * MAC_BW;
    localparam int TW     = LW + 6;
    localparam int ACC_BW = TW + ACC_EXT;
    localparam int RW     = ACC_BW + 1;
    localparam int OMAX_I = (1 << (OUT_BW - 1)) - 1;
    localparam logic signed [RW-1:0] OMAX = RW'(OMAX_I);
    localparam logic signed [RW-1:0] OMIN = RW'(-OMAX_I - 1);

    logic en;
    logic out_valid_q;

    // valid/ready: a beat moves on a rising edge with in_valid && in_ready; a result
    // leaves on out_valid && out_ready; a stalled result freezes the whole pipeline.
    assign en        = !out_valid_q || out_ready;
    assign in_ready  = en && !rst;
    assign out_valid = out_valid_q;

    logic signed [LW-1:0] lane;
    logic signed [TW-1:0] part_d [NG];

    always_comb begin
        lane = '0;
        for (int p = 0; p < NG; p++) begin
            part_d[p] = '0;
            for (int l = 0; l < 8; l++) begin
                lane      = iC[(p*8+l)*LW +: LW];
                part_d[p] = part_d[p] + TW'(lane);
            end
        end
    end

    logic                 p1_valid_q, p1_last_q;
    logic [1:0]           p1_mode_q;
    logic [4:0]           p1_shift_q;
    logic signed [TW-1:0] p1_part_q [NG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_valid_q <= 1'b0;
            p1_last_q  <= 1'b0;
            p1_mode_q  <= '0;
            p1_shift_q <= '0;
            for (int p = 0; p < NG; p++) p1_part_q[p] <= '0;
        end else if (en) begin
            p1_valid_q <= in_valid;
            p1_last_q  <= in_last;
            p1_mode_q  <= mode;
            p1_shift_q <= shift;
            p1_part_q  <= part_d;
        end
    end

    // Partial k belongs to group k >> (3 - mode); higher groups simply collect nothing.
    logic signed [TW-1:0] grp_d [NG];

    always_comb begin
        for (int g = 0; g < NG; g++) begin
            grp_d[g] = '0;
            for (int k = 0; k < NG; k++) begin
                if ((k >> (3 - int'(p1_mode_q))) == g) grp_d[g] = grp_d[g] + p1_part_q[k];
            end
        end
    end

    logic                 p2_valid_q, p2_last_q;
    logic [4:0]           p2_shift_q;
    logic signed [TW-1:0] p2_grp_q [NG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p2_valid_q <= 1'b0;
            p2_last_q  <= 1'b0;
            p2_shift_q <= '0;
            for (int g = 0; g < NG; g++) p2_grp_q[g] <= '0;
        end else if (en) begin
            p2_valid_q <= p1_valid_q;
            p2_last_q  <= p1_last_q;
            p2_shift_q <= p1_shift_q;
            p2_grp_q   <= grp_d;
        end
    end

    logic                     first_q;
    logic signed [ACC_BW-1:0] acc_q [NG];
    logic signed [ACC_BW-1:0] acc_base;
    logic signed [ACC_BW-1:0] acc_d [NG];
    logic signed [RW-1:0]     wide, rnd;
    logic [OUT_BW-1:0]        res_d [NG];
    logic [NG-1:0]            sat_d;
    logic [OUT_BW-1:0]        od_q [NG];
    logic [NG-1:0]            sat_q;

    // One extra bit of headroom keeps the rounding add from wrapping before the shift.
    always_comb begin
        acc_base = '0;
        wide     = '0;
        rnd      = '0;
        sat_d    = '0;
        for (int g = 0; g < NG; g++) begin
            acc_base = first_q ? '0 : acc_q[g];
            acc_d[g] = acc_base + ACC_BW'(p2_grp_q[g]);
            wide     = RW'(acc_d[g]);
            if (p2_shift_q != 5'd0) begin
                rnd  = RW'(1) << (p2_shift_q - 5'd1);
                wide = (wide + rnd) >>> p2_shift_q;
            end
            if (wide > OMAX) begin
                res_d[g] = OMAX[OUT_BW-1:0];
                sat_d[g] = 1'b1;
            end else if (wide < OMIN) begin
                res_d[g] = OMIN[OUT_BW-1:0];
                sat_d[g] = 1'b1;
            end else begin
                res_d[g] = wide[OUT_BW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_q     <= 1'b1;
            out_valid_q <= 1'b0;
            sat_q       <= '0;
            for (int g = 0; g < NG; g++) begin
                acc_q[g] <= '0;
                od_q[g]  <= '0;
            end
        end else if (en) begin
            out_valid_q <= p2_valid_q && p2_last_q;
            if (p2_valid_q) begin
                acc_q   <= acc_d;
                first_q <= p2_last_q;
                if (p2_last_q) begin
                    od_q  <= res_d;
                    sat_q <= sat_d;
                end
            end
        end
    end

    for (genvar g = 0; g < NG; g++) begin : g_out
        assign oD[g*OUT_BW +: OUT_BW] = od_q[g];
    end
    assign out_sat = sat_q;

endmodule

// File: tb/tb_simd_reduce_drain.sv
// Directed bench for simd_reduce_drain: vector table of single-beat packets plus
// hand-written multi-beat, backpressure and mid-packet reset sequences.
module tb_simd_reduce_drain;
    localparam int W = 8*16 + 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    mode = '0;
    logic [4:0]    shift = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_last = 1'b0;
    logic [1023:0] iC = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [127:0]  oD;
    logic [7:0]    out_sat;

    simd_reduce_drain dut (
        .clk(clk), .rst(rst), .mode(mode), .shift(shift),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .iC(iC),
        .out_valid(out_valid), .out_ready(out_ready), .oD(oD), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       mode;
        logic [4:0]       shift;
        int               base;
        int               step;
        logic [7:0][15:0] d;
        logic [7:0]       sat;
    } vec_t;

    int            n_run = 0;
    int            n_fail = 0;
    int            n_results = 0;
    logic [W-1:0]  exp_q[$];
    vec_t          vecs[11];

    function automatic vec_t mk(input logic [1:0] m, input logic [4:0] s, input int b, input int st,
                                input int e0, input int e1, input int e2, input int e3,
                                input int e4, input int e5, input int e6, input int e7,
                                input logic [7:0] sat);
        vec_t v;
        v.mode = m; v.shift = s; v.base = b; v.step = st; v.sat = sat;
        v.d[0] = 16'(e0); v.d[1] = 16'(e1); v.d[2] = 16'(e2); v.d[3] = 16'(e3);
        v.d[4] = 16'(e4); v.d[5] = 16'(e5); v.d[6] = 16'(e6); v.d[7] = 16'(e7);
        return v;
    endfunction

    function automatic logic [W-1:0] pack(input vec_t v);
        return {v.d, v.sat};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted result must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_results++;
            if (exp_q.size() == 0) begin
                n_run++;
                n_fail++;
                $display("FAIL unexpected_result: got %h, expected none", {oD, out_sat});
            end else begin
                check("result", {oD, out_sat}, exp_q.pop_front());
            end
        end
    end

    // Called and returns at #1 after a rising edge; in_valid stays high for back-to-back use.
    task automatic send_beat(input logic [1:0] m, input logic [4:0] s, input int b, input int st,
                             input logic last, output int tries);
        logic ok;
        mode = m; shift = s; in_last = last; in_valid = 1'b1;
        for (int i = 0; i < 64; i++) iC[i*16 +: 16] = 16'(b + i*st);
        ok = 1'b0;
        tries = 0;
        while (!ok) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            tries++;
            if (!ok && tries > 50) begin
                check("accept_timeout", {31'd0, ok}, 32'd1);
                break;
            end
        end
    endtask

    task automatic wait_drain(input string name);
        int b;
        b = 0;
        while (exp_q.size() != 0 && b < 100) begin
            @(negedge clk);
            b++;
        end
        if (exp_q.size() != 0) begin
            check(name, W'(exp_q.size()), '0);
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int tries;
        int n0;
        int b;
        logic [2:0] lat;

        vecs[0]  = mk(2'b00, 5'd0, 1, 0, 64, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        vecs[1]  = mk(2'b11, 5'd0, 0, 1, 28, 92, 156, 220, 284, 348, 412, 476, 8'h00);
        vecs[2]  = mk(2'b10, 5'd0, 0, 1, 120, 376, 632, 888, 0, 0, 0, 0, 8'h00);
        vecs[3]  = mk(2'b01, 5'd0, 0, 1, 496, 1520, 0, 0, 0, 0, 0, 0, 8'h00);
        vecs[4]  = mk(2'b00, 5'd0, 32767, 0, 32767, 0, 0, 0, 0, 0, 0, 0, 8'h01);
        vecs[5]  = mk(2'b00, 5'd7, 32767, 0, 16384, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        vecs[6]  = mk(2'b00, 5'd0, -32768, 0, -32768, 0, 0, 0, 0, 0, 0, 0, 8'h01);
        vecs[7]  = mk(2'b00, 5'd3, 1, 0, 8, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        vecs[8]  = mk(2'b11, 5'd4, 3, 0, 2, 2, 2, 2, 2, 2, 2, 2, 8'h00);
        vecs[9]  = mk(2'b11, 5'd4, -3, 0, -1, -1, -1, -1, -1, -1, -1, -1, 8'h00);
        vecs[10] = mk(2'b10, 5'd1, -1, 0, -8, -8, -8, -8, 0, 0, 0, 0, 8'h00);

        repeat (2) @(negedge clk);
        check("reset_data", {oD, out_sat}, '0);
        check("reset_flags", W'({out_valid, in_ready}), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Latency: accepted in cycle n, out_valid visible in cycle n+3.
        exp_q.push_back(pack(vecs[0]));
        send_beat(2'b00, 5'd0, 1, 0, 1'b1, tries);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            lat[i] = out_valid;
        end
        check("latency", W'(lat), W'(3'b100));
        wait_drain("latency_drain");

        for (int v = 0; v < 11; v++) begin
            exp_q.push_back(pack(vecs[v]));
            send_beat(vecs[v].mode, vecs[v].shift, vecs[v].base, vecs[v].step, 1'b1, tries);
            in_valid = 1'b0;
            wait_drain("vector_drain");
        end

        // Three-beat packet: no result until the last beat.
        exp_q.push_back(pack(mk(2'b01, 5'd0, 0, 0, -192, -192, 0, 0, 0, 0, 0, 0, 8'h00)));
        n0 = n_results;
        send_beat(2'b01, 5'd0, -2, 0, 1'b0, tries);
        send_beat(2'b01, 5'd0, -2, 0, 1'b0, tries);
        send_beat(2'b01, 5'd0, -2, 0, 1'b1, tries);
        in_valid = 1'b0;
        wait_drain("multibeat_drain");
        check("multibeat_count", W'(n_results - n0), W'(1));

        // Back-to-back packets under a stalled output.
        out_ready = 1'b0;
        exp_q.push_back(pack(mk(2'b00, 5'd0, 0, 0, 64, 0, 0, 0, 0, 0, 0, 0, 8'h00)));
        exp_q.push_back(pack(mk(2'b00, 5'd0, 0, 0, 128, 0, 0, 0, 0, 0, 0, 0, 8'h00)));
        n0 = n_results;
        send_beat(2'b00, 5'd0, 1, 0, 1'b1, tries);
        send_beat(2'b00, 5'd0, 2, 0, 1'b1, tries);
        in_valid = 1'b0;
        b = 0;
        while (!out_valid && b < 20) begin
            @(negedge clk);
            b++;
        end
        check("stall_valid", W'(out_valid), W'(1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_hold", W'({oD[15:0], in_ready, out_valid}), W'({16'd64, 1'b0, 1'b1}));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain("b2b_drain");
        repeat (3) @(negedge clk);
        check("b2b_count", W'(n_results - n0), W'(2));
        @(posedge clk);
        #1;

        // Mid-packet reset discards the partial accumulation.
        send_beat(2'b00, 5'd0, 5, 0, 1'b0, tries);
        send_beat(2'b00, 5'd0, 5, 0, 1'b0, tries);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midreset_data", {oD, out_sat}, '0);
        check("midreset_flags", W'({out_valid, in_ready}), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.push_back(pack(mk(2'b00, 5'd0, 0, 0, 64, 0, 0, 0, 0, 0, 0, 0, 8'h00)));
        send_beat(2'b00, 5'd0, 1, 0, 1'b1, tries);
        in_valid = 1'b0;
        check("ready_after_reset", W'(tries), W'(1));
        wait_drain("reset_drain");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
